// File: rtl/controla_display.sv
// controla_display: arbitrates the vending machine's shared 4-digit, 7-segment display.
// It picks the highest-priority message source and holds that message for HOLD_CYCLES
// after the source drops. The four active-low digit enables are scanned continuously.
module controla_display #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned SCAN_DIV    = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       view_bebida_i,
    input  logic [6:0] seg_bebida_i,
    input  logic       sinal_cancel_i,
    input  logic       v_sense_i,
    input  logic       d_valor_i,
    output logic [3:0] digits_o,
    output logic [6:0] segments_o,
    output logic       ocupado_o,
    output logic [2:0] estado_o
);

    // HOLD_CYCLES >= 2, so the timer is always at least one bit wide.
    localparam int unsigned TimerW = $clog2(HOLD_CYCLES);
    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TimerW-1:0] HoldReload = TimerW'(HOLD_CYCLES - 1);
    localparam logic [ScanW-1:0]  ScanLast   = ScanW'(SCAN_DIV - 1);

    // Active-low glyphs, bit6=g ... bit0=a.
    localparam logic [6:0] GlyphDash  = 7'b0111111;
    localparam logic [6:0] GlyphE     = 7'b0000110;
    localparam logic [6:0] GlyphC     = 7'b1000110;
    localparam logic [6:0] GlyphBlank = 7'b1111111;

    // State codes double as priorities: a larger code always wins.
    typedef enum logic [2:0] {
        StOcioso      = 3'd0,
        StBebida      = 3'd1,
        StErroValor   = 3'd2,
        StErroSensor  = 3'd3,
        StCancela     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    state_e              winner;
    logic                preempt;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [6:0]          latch_q, latch_d;
    logic [ScanW-1:0]    scan_q, scan_d;
    logic [1:0]          idx_q, idx_d;

    // Fixed-priority pick of the strongest asserted event this cycle.
    always_comb begin
        winner = StOcioso;
        if (sinal_cancel_i) begin
            winner = StCancela;
        end else if (v_sense_i) begin
            winner = StErroSensor;
        end else if (d_valor_i) begin
            winner = StErroValor;
        end else if (view_bebida_i && (seg_bebida_i != GlyphBlank)) begin
            // A blank drink pattern carries no information and is ignored.
            winner = StBebida;
        end
    end

    // An event takes over when it is at least as important as what is showing.
    assign preempt = (winner != StOcioso) && (3'(winner) >= 3'(state_q));

    // Next message state, hold timer and drink latch.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        latch_d = latch_q;
        if (preempt) begin
            state_d = winner;
            timer_d = HoldReload;
            if (winner == StBebida) begin
                latch_d = seg_bebida_i;
            end
        end else if (timer_q == '0) begin
            state_d = StOcioso;
        end else begin
            timer_d = timer_q - TimerW'(1);
        end
    end

    // Free-running digit scan, independent of the message state.
    always_comb begin
        scan_d = scan_q;
        idx_d  = idx_q;
        if (scan_q == ScanLast) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + ScanW'(1);
        end
    end

    // State, timer, latch and scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StOcioso;
            timer_q <= '0;
            latch_q <= GlyphBlank;
            scan_q  <= '0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            latch_q <= latch_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
        end
    end

    // Display outputs decode only registered values, so they cannot glitch on input changes.
    always_comb begin
        digits_o   = ~(4'b0001 << idx_q);
        ocupado_o  = (state_q != StOcioso);
        estado_o   = state_q;
        segments_o = GlyphDash;
        unique case (state_q)
            StOcioso:     segments_o = GlyphDash;
            StBebida:     segments_o = (idx_q == 2'd0) ? latch_q : GlyphBlank;
            StErroValor:  segments_o = (idx_q == 2'd0) ? GlyphE : GlyphBlank;
            StErroSensor: segments_o = GlyphE;
            StCancela:    segments_o = GlyphC;
            default:      segments_o = GlyphDash;
        endcase
    end

endmodule

// File: tb/tb_controla_display.sv
// Bench for controla_display with HOLD_CYCLES=8 and SCAN_DIV=4.
// It uses an edge-numbered behavioural model plus directed literal checks.
module tb_controla_display;

    localparam int HOLD = 8;
    localparam int SCAN = 4;

    logic       clk;
    logic       rst_n;
    logic       view_bebida;
    logic [6:0] seg_bebida;
    logic       sinal_cancel;
    logic       v_sense;
    logic       d_valor;
    logic [3:0] digits;
    logic [6:0] segments;
    logic       ocupado;
    logic [2:0] estado;

    int n_tests;
    int n_fail;
    bit cmp_en;

    controla_display #(
        .HOLD_CYCLES(HOLD),
        .SCAN_DIV   (SCAN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .view_bebida_i (view_bebida),
        .seg_bebida_i  (seg_bebida),
        .sinal_cancel_i(sinal_cancel),
        .v_sense_i     (v_sense),
        .d_valor_i     (d_valor),
        .digits_o      (digits),
        .segments_o    (segments),
        .ocupado_o     (ocupado),
        .estado_o      (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_cyc counts clock edges since reset. A message ends at the first edge at or past
    // m_deadline that carries no qualifying event.
    int         m_state;
    int         m_deadline;
    int         m_cyc;
    logic [6:0] m_latch;

    function automatic int winner_of(input logic c, input logic vs, input logic dv,
                                     input logic vb, input logic [6:0] sb);
        if (c) return 4;
        if (vs) return 3;
        if (dv) return 2;
        if (vb && sb != 7'h7f) return 1;
        return 0;
    endfunction

    function automatic logic [6:0] exp_segments(input int st, input logic [6:0] lat, input int idx);
        case (st)
            4: return 7'b1000110;
            3: return 7'b0000110;
            2: return (idx == 0) ? 7'b0000110 : 7'b1111111;
            1: return (idx == 0) ? lat : 7'b1111111;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic logic [3:0] exp_digits(input int cyc);
        return 4'b1111 ^ (4'b0001 << ((cyc / SCAN) % 4));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state    <= 0;
            m_deadline <= 0;
            m_cyc      <= 0;
            m_latch    <= 7'h7f;
        end else begin
            m_cyc <= m_cyc + 1;
            if (winner_of(sinal_cancel, v_sense, d_valor, view_bebida, seg_bebida) > 0 &&
                winner_of(sinal_cancel, v_sense, d_valor, view_bebida, seg_bebida) >= m_state) begin
                m_state    <= winner_of(sinal_cancel, v_sense, d_valor, view_bebida, seg_bebida);
                m_deadline <= m_cyc + 1 + HOLD;
                if (winner_of(sinal_cancel, v_sense, d_valor, view_bebida, seg_bebida) == 1)
                    m_latch <= seg_bebida;
            end else if (m_cyc + 1 >= m_deadline) begin
                m_state <= 0;
            end
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_digits", 32'(digits), 32'(exp_digits(m_cyc)));
            check("cmp_segments", 32'(segments),
                  32'(exp_segments(m_state, m_latch, (m_cyc / SCAN) % 4)));
            check("cmp_estado", 32'(estado), 32'(m_state));
            check("cmp_ocupado", 32'(ocupado), 32'(m_state != 0));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [3:0] dig_tab [4];
    int cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cmp_en  = 1'b0;
        dig_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        rst_n        = 1'b0;
        view_bebida  = 1'b0;
        seg_bebida   = 7'h7f;
        sinal_cancel = 1'b0;
        v_sense      = 1'b0;
        d_valor      = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: idle scan, each digit held SCAN cycles.
        for (int k = 0; k < 8; k++) begin
            check("idle_digits", 32'(digits), 32'(dig_tab[k % 4]));
            check("idle_dash", 32'(segments), 32'(7'b0111111));
            check("idle_estado", 32'(estado), 32'd0);
            check("idle_ocupado", 32'(ocupado), 32'd0);
            step(4);
        end

        // 2: one-cycle drink request shows for exactly HOLD cycles; later seg changes ignored.
        view_bebida = 1'b1;
        seg_bebida  = 7'b0011001;
        step(1);
        view_bebida = 1'b0;
        seg_bebida  = 7'b1000000;
        cnt = 0;
        while (estado == 3'd1 && cnt < 20) begin
            cnt++;
            if (digits == 4'b1110) check("bebida_d0", 32'(segments), 32'(7'b0011001));
            else check("bebida_blank", 32'(segments), 32'(7'b1111111));
            step(1);
        end
        check("bebida_len", 32'(cnt), 32'd8);
        check("bebida_end", 32'(estado), 32'd0);

        // 3: value error preempts a drink; a later drink request is ignored.
        view_bebida = 1'b1;
        seg_bebida  = 7'b0011001;
        step(1);
        view_bebida = 1'b0;
        check("b3_enter", 32'(estado), 32'd1);
        step(2);
        d_valor = 1'b1;
        step(1);
        d_valor = 1'b0;
        check("valor_now", 32'(estado), 32'd2);
        for (int k = 1; k < 8; k++) begin
            if (k == 2) begin
                view_bebida = 1'b1;
                seg_bebida  = 7'b0011001;
            end
            step(1);
            view_bebida = 1'b0;
            check("valor_hold", 32'(estado), 32'd2);
        end
        step(1);
        check("valor_end", 32'(estado), 32'd0);

        // 4: simultaneous events, cancel wins.
        sinal_cancel = 1'b1;
        v_sense      = 1'b1;
        view_bebida  = 1'b1;
        step(1);
        sinal_cancel = 1'b0;
        v_sense      = 1'b0;
        view_bebida  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("cancel_estado", 32'(estado), 32'd4);
            check("cancel_seg", 32'(segments), 32'(7'b1000110));
            step(1);
        end
        check("cancel_end", 32'(estado), 32'd0);

        // 5: held sensor fault is sampled on 20 edges, then shown 8 more cycles after release.
        v_sense = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("sensor_held", 32'(estado), 32'd3);
            check("sensor_ocup", 32'(ocupado), 32'd1);
            check("sensor_seg", 32'(segments), 32'(7'b0000110));
        end
        v_sense = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            check("sensor_tail", 32'(estado), 32'd3);
        end
        step(1);
        check("sensor_end", 32'(estado), 32'd0);

        // 6: asynchronous reset in the middle of a cancel message.
        sinal_cancel = 1'b1;
        step(1);
        sinal_cancel = 1'b0;
        step(2);
        check("pre_rst", 32'(estado), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("rst_digits", 32'(digits), 32'(4'b1110));
        check("rst_seg", 32'(segments), 32'(7'b0111111));
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(4);
        check("post_rst_digits", 32'(digits), 32'(4'b1101));
        check("post_rst_estado", 32'(estado), 32'd0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
